mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified memory between instruction fetch and data load/store.
//  Serialises requests, issues exactly one memory command per transaction and returns
//  read data to the owning requester with a one-cycle done pulse.
//  Sits between the fetch/writeback stages driven by the control FSM and the memory.
// PARAMETERS
//  ADDR_W   16  address width, both requesters and memory
//  DATA_W   32  data width
//  MEM_LAT  2   cycles from mem_en high to mem_rdata valid; >=1, else elaboration error
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  halt       in   1       high: no new grants; in-flight transaction completes
//  if_req     in   1       fetch request (read only), level
//  if_addr    in   ADDR_W  fetch address, stable while if_req high
//  if_rdata   out  DATA_W  fetched word, valid with if_done, held until next if_done
//  if_done    out  1       one-cycle pulse: fetch complete
//  d_req      in   1       data request, level
//  d_we       in   1       1=store, 0=load; stable while d_req high
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid with d_done, held; unchanged on store
//  d_done     out  1       one-cycle pulse: load/store complete
//  mem_en     out  1       memory command strobe, exactly one cycle per transaction
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  DATA_W  latched store data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1       state != IDLE
//  owner      out  1       0=fetch, 1=data; current/last granted requester
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; last_owner=1 (fetch wins first conflict).
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs registered.
//  IDLE: if !halt and any req: pick owner, latch addr/we/wdata (fetch: we=0) -> ISSUE.
//   Only one req high: grant it. Both high: grant !last_owner (round-robin), update last_owner.
//  ISSUE (1 cycle): mem_en=1, mem_we/addr/wdata from latch; load wait counter to MEM_LAT-1.
//  WAIT: counter decrements; at 0 capture mem_rdata into owner's rdata reg (loads/fetches only) -> RESP.
//   MEM_LAT=1: WAIT lasts one cycle with counter already 0.
//  RESP (1 cycle): owner's done=1 -> IDLE.
//  Latency: req sampled in IDLE at cycle t -> mem_en at t+1 -> done at t+MEM_LAT+2 (t+4 default).
//  Throughput: one transaction per MEM_LAT+3 cycles; no back-to-back overlap.
//  Handshake: req high in IDLE = new transaction. Requester drops req on edge ending done cycle
//   unless it wants another access; a held req is re-arbitrated as a fresh request.
//  req dropped mid-transaction: ignored; transaction completes and done still pulses.
//  Inputs addr/we/wdata changing mid-transaction: no effect (latched in IDLE).
//  halt rising mid-transaction: transaction completes; FSM then stays IDLE, busy=0.
//  halt and req both high in IDLE: no grant, no mem_en.
//  rst mid-transaction: immediate return to IDLE, mem_en/done forced 0, pending read
//   data discarded, rdata regs cleared; no done pulse for the aborted transaction.
//  Counter width $clog2(MEM_LAT+1); never wraps (reloaded in ISSUE only).
// STRUCTURE
//  Shared package mem_arb_pkg: state encodings (IDLE/ISSUE/WAIT/RESP, 2 bits),
//   OWNER_IF=1'b0, OWNER_D=1'b1.
//  Sub-module rr_arb2: 2-way round-robin pick (req[1:0], last_owner -> grant owner), combinational.
//  Rest (FSM, latches, counter, rdata regs) lives in mem_port_arbiter.
// TESTING
//  if_req=1 addr=0x0010, mem returns 0xDEADBEEF at MEM_LAT -> mem_en at t+1, if_done at t+4, if_rdata=0xDEADBEEF.
//  d_req=1 d_we=1 addr=0x0200 wdata=0x12345678 -> one mem_en with mem_we=1, d_done at t+4, d_rdata unchanged.
//  if_req and d_req both high from reset, held -> order fetch, data, fetch, data; owner alternates.
//  halt=1 during data load -> load completes with d_done; further reqs get no mem_en, busy=0.
//  rst pulsed in WAIT -> outputs 0 asynchronously, no done; next req after release served normally.
//  MEM_LAT=1 and MEM_LAT=5 builds -> done at t+3 and t+7; exactly one mem_en per transaction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//  state_e  : arbiter FSM encoding (IDLE -> ISSUE -> WAIT -> RESP).
//  OWNER_IF : fetch requester id.
//  OWNER_D  : data load/store requester id.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//  req[0]      : fetch request
//  req[1]      : data request
//  last_owner  : requester that won the previous conflict
//  grant_owner : selected requester (only meaningful when any req is high)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_owner
);

  always_comb begin
    grant_owner = OWNER_IF;
    if (req == 2'b11) begin
      // Conflict: the side that lost last time wins now.
      grant_owner = ~last_owner;
    end else if (req[1]) begin
      grant_owner = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between instruction fetch and data load/store.
// One transaction at a time: one mem_en strobe, wait MEM_LAT cycles, capture
// read data for the owner, then a one-cycle done pulse to that owner.
// Ports:
//  clk, rst                 : clock, asynchronous active-high reset
//  halt                     : blocks new grants, in-flight transaction finishes
//  if_req/if_addr           : fetch request (read only)
//  if_rdata/if_done         : fetched word (held) and completion pulse
//  d_req/d_we/d_addr/d_wdata: data request, 1=store
//  d_rdata/d_done           : load data (held, untouched by stores) and pulse
//  mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory command and read data
//  busy                     : FSM not idle
//  owner                    : current/last granted requester (0=fetch, 1=data)
// All outputs come straight from flops.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_owner_q, last_owner_d;
  logic                owner_q, owner_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;
  logic                busy_q, busy_d;
  logic                grant_owner;

  rr_arb2 u_rr_arb2 (
    .req         ({d_req, if_req}),
    .last_owner  (last_owner_q),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!halt && (if_req || d_req)) begin
          owner_d = grant_owner;
          // Round-robin history only moves when both sides competed.
          if (if_req && d_req) begin
            last_owner_d = grant_owner;
          end
          if (grant_owner == OWNER_D) begin
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d  = if_addr;
            mem_we_d    = 1'b0;
          end
          // mem_en is raised together with the move into ISSUE so it is
          // high for exactly the ISSUE cycle.
          mem_en_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // mem_rdata is valid in this cycle; stores leave rdata untouched.
          if (owner_q == OWNER_D) begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_done_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= OWNER_D;
      owner_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      busy_q       <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, halt;
  logic        if_req, if_done, d_req, d_we, d_done;
  logic        mem_en, mem_we, busy, owner;
  logic [15:0] if_addr, d_addr, mem_addr;
  logic [31:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_init(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a ^ 16'h5A5A};
  endfunction

  // Memory model: single outstanding command, data valid LAT cycles after mem_en.
  int          m_cnt = 0;
  logic [15:0] m_addr = '0;
  bit          wr_v[256];
  logic [31:0] wr_m[256];
  always @(posedge clk) begin
    if (mem_en) begin
      m_cnt  <= 1;
      m_addr <= mem_addr;
      if (mem_we) begin
        wr_v[mem_addr[7:0]] <= 1'b1;
        wr_m[mem_addr[7:0]] <= mem_wdata;
      end
    end else if (m_cnt != 0 && m_cnt < 15) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign mem_rdata = (m_cnt == LAT) ?
                     (wr_v[m_addr[7:0]] ? wr_m[m_addr[7:0]] : mem_init(m_addr)) :
                     32'hBAD0BAD0;

  // Scoreboard
  typedef struct {
    logic        own;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          en_cyc;
  } txn_t;

  txn_t        cmd_q[$];
  txn_t        rsp_q[$];
  bit          sh_v[256];
  logic [31:0] sh_m[256];
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d  = '0;
  int          n_en = 0;
  int          last_en_cyc = 0;

  function automatic logic [31:0] sh_read(input logic [15:0] a);
    return sh_v[a[7:0]] ? sh_m[a[7:0]] : mem_init(a);
  endfunction

  task automatic push_txn(input logic own, input logic we, input logic [15:0] addr,
                          input logic [31:0] wd, input int en_cyc);
    txn_t t;
    t.own = own; t.we = we; t.addr = addr; t.wdata = wd; t.en_cyc = en_cyc;
    if (own == OWNER_IF) begin
      exp_if = sh_read(addr); t.rdata = exp_if;
    end else if (!we) begin
      exp_d = sh_read(addr); t.rdata = exp_d;
    end else begin
      sh_v[addr[7:0]] = 1'b1; sh_m[addr[7:0]] = wd; t.rdata = exp_d;
    end
    cmd_q.push_back(t);
    rsp_q.push_back(t);
  endtask

  initial begin
    txn_t e, r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_en) begin
          n_en++;
          last_en_cyc = cyc;
          if (cmd_q.size() == 0) check_eq("mem_en_unexpected", mem_en, 1'b0);
          else begin
            e = cmd_q.pop_front();
            check_eq("mem_addr", mem_addr, e.addr);
            check_eq("mem_we", mem_we, e.we);
            if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
            if (e.en_cyc >= 0) check_eq("mem_en_cycle", cyc, e.en_cyc);
          end
        end
        if (if_done || d_done) begin
          if (rsp_q.size() == 0) check_eq("done_unexpected", {if_done, d_done}, 2'b00);
          else begin
            r = rsp_q.pop_front();
            check_eq("done_select", {if_done, d_done}, r.own ? 2'b01 : 2'b10);
            check_eq("done_latency", cyc - last_en_cyc, LAT + 1);
            check_eq("owner", owner, r.own);
            if (r.own) check_eq("d_rdata", d_rdata, r.rdata);
            else       check_eq("if_rdata", if_rdata, r.rdata);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (rsp_q.size() == 0) break;
      tick(1);
    end
    check_eq("drain_pending", rsp_q.size(), 0);
  endtask

  // Request held one cycle, then dropped and inputs scrambled: the latched
  // command must be unaffected and done must still arrive.
  task automatic do_single(input logic own, input logic we, input logic [15:0] addr,
                           input logic [31:0] wd);
    int en0;
    en0 = n_en;
    push_txn(own, we, addr, wd, cyc + 1);
    if (own == OWNER_D) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    tick(1);
    if_req = 1'b0; d_req = 1'b0;
    d_we = ~we; d_addr = ~addr; if_addr = ~addr; d_wdata = ~wd;
    wait_drain(20);
    check_eq("mem_en_count", n_en - en0, 1);
  endtask

  // Separate builds with MEM_LAT=1 and MEM_LAT=5, fetch-only traffic.
  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int AL = (g == 0) ? 1 : 5;
    logic        a_rst, a_if_req, a_if_done, a_d_done, a_mem_en, a_mem_we, a_busy, a_owner;
    logic [15:0] a_if_addr, a_mem_addr;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
    int          a_cnt = 0;
    logic [15:0] a_la = '0;
    bit          fin = 1'b0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(AL)) dut_alt (
      .clk(clk), .rst(a_rst), .halt(1'b0),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_done(a_if_done),
      .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(32'h0),
      .d_rdata(a_d_rdata), .d_done(a_d_done),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
    );

    always @(posedge clk) begin
      if (a_mem_en) begin
        a_cnt <= 1;
        a_la  <= a_mem_addr;
      end else if (a_cnt != 0 && a_cnt < 15) begin
        a_cnt <= a_cnt + 1;
      end
    end
    assign a_mem_rdata = (a_cnt == AL) ? mem_init(a_la) : 32'hBAD0BAD0;

    initial begin
      int          t, en_n, en_c, done_c;
      logic [31:0] rd;
      logic [15:0] addr;
      a_rst = 1'b1; a_if_req = 1'b0; a_if_addr = '0;
      tick(3);
      a_rst = 1'b0;
      tick(1);
      for (int k = 0; k < 2; k++) begin
        addr = 16'h0020 + 16'(k * 4);
        t = cyc; en_n = 0; en_c = -1; done_c = -1; rd = '0;
        a_if_req = 1'b1; a_if_addr = addr;
        for (int i = 0; i < AL + 6; i++) begin
          @(negedge clk);
          if (a_mem_en) begin en_n++; en_c = cyc; end
          if (a_if_done) begin done_c = cyc; rd = a_if_rdata; a_if_req = 1'b0; end
        end
        check_eq($sformatf("lat%0d_en_cycle", AL), en_c, t + 1);
        check_eq($sformatf("lat%0d_done_cycle", AL), done_c, t + AL + 2);
        check_eq($sformatf("lat%0d_en_count", AL), en_n, 1);
        check_eq($sformatf("lat%0d_rdata", AL), rd, mem_init(addr));
        tick(1);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int en0, t;
    rst = 1'b1; halt = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tick(3);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_owner", owner, 1'b0);
    check_eq("rst_mem_en", mem_en, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 16'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_if_done", if_done, 1'b0);
    check_eq("rst_d_done", d_done, 1'b0);
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    check_eq("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;
    tick(2);

    // Fetch of 0x0010 returning 0xDEADBEEF, with busy/mem_en in the ISSUE cycle.
    push_txn(OWNER_IF, 1'b0, 16'h0010, 32'h0, cyc + 1);
    if_req = 1'b1; if_addr = 16'h0010;
    tick(1);
    check_eq("busy_issue", busy, 1'b1);
    check_eq("mem_en_issue", mem_en, 1'b1);
    if_req = 1'b0; if_addr = 16'hFFFF;
    wait_drain(20);
    check_eq("busy_idle", busy, 1'b0);
    check_eq("mem_en_idle", mem_en, 1'b0);

    // Load, store (d_rdata must not move), load-back, another fetch.
    do_single(OWNER_D, 1'b0, 16'h0040, 32'h0);
    do_single(OWNER_D, 1'b1, 16'h0200, 32'h12345678);
    check_eq("if_rdata_hold", if_rdata, 32'hDEADBEEF);
    do_single(OWNER_D, 1'b0, 16'h0200, 32'h0);
    do_single(OWNER_IF, 1'b0, 16'h0080, 32'h0);
    check_eq("d_rdata_hold", d_rdata, 32'h12345678);

    // Both requests held from reset: fetch, data, fetch, data.
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    exp_if = '0; exp_d = '0;
    t = cyc;
    push_txn(OWNER_IF, 1'b0, 16'h0100, 32'h0, t + 1);
    push_txn(OWNER_D,  1'b0, 16'h0104, 32'h0, t + 6);
    push_txn(OWNER_IF, 1'b0, 16'h0100, 32'h0, t + 11);
    push_txn(OWNER_D,  1'b0, 16'h0104, 32'h0, t + 16);
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0104;
    for (int i = 0; i < 40 && rsp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    check_eq("rr_pending", rsp_q.size(), 0);
    tick(6);

    // halt raised during a load: load completes, then no more grants.
    push_txn(OWNER_D, 1'b0, 16'h0300, 32'h0, cyc + 1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    tick(1);
    d_req = 1'b0;
    tick(1);
    halt = 1'b1; if_req = 1'b1; if_addr = 16'h0050;
    wait_drain(20);
    en0 = n_en;
    tick(10);
    check_eq("halt_no_mem_en", n_en - en0, 0);
    check_eq("halt_busy", busy, 1'b0);
    halt = 1'b0;
    push_txn(OWNER_IF, 1'b0, 16'h0050, 32'h0, cyc + 1);
    tick(1);
    if_req = 1'b0;
    wait_drain(20);

    // Asynchronous reset in WAIT: everything cleared, no done afterwards.
    push_txn(OWNER_IF, 1'b0, 16'h0060, 32'h0, cyc + 1);
    if_req = 1'b1; if_addr = 16'h0060;
    tick(1);
    if_req = 1'b0;
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_mem_en", mem_en, 1'b0);
    check_eq("arst_mem_addr", mem_addr, 16'h0);
    check_eq("arst_if_done", if_done, 1'b0);
    check_eq("arst_d_done", d_done, 1'b0);
    check_eq("arst_if_rdata", if_rdata, 32'h0);
    check_eq("arst_d_rdata", d_rdata, 32'h0);
    check_eq("arst_owner", owner, 1'b0);
    rsp_q.delete(); cmd_q.delete();
    exp_if = '0; exp_d = '0;
    tick(2);
    rst = 1'b0;
    en0 = n_en;
    tick(6);
    check_eq("arst_no_mem_en", n_en - en0, 0);
    do_single(OWNER_IF, 1'b0, 16'h0060, 32'h0);

    for (int i = 0; i < 200 && !(g_alt[0].fin && g_alt[1].fin); i++) tick(1);
    check_eq("alt_builds_finished", {g_alt[0].fin, g_alt[1].fin}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
